// File: rtl/muller_c_pkg.sv
// Shared types for the Muller C-element sequencer: FSM state encoding and error codes.
package muller_c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_A,
        SET_B,
        CLR,
        FIN,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_HOLD    = 2'd1;
    localparam logic [1:0] ERR_RISE_TO = 2'd2;
    localparam logic [1:0] ERR_FALL_TO = 2'd3;

endpackage

// File: rtl/muller_c_sync.sv
// Multi-flop synchronizer for a single asynchronous input, async active-low reset.
module muller_c_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/muller_c_seq_arbiter.sv
// Round-robin sequencer sharing one Muller C-element: drives a 4-phase RTZ cycle on c_a/c_b,
// checks the hold property and reports done/err per granted transaction.
module muller_c_seq_arbiter
    import muller_c_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [TO_W-1:0]    timeout_lim,
    input  logic               c_q,
    output logic [NUM_REQ-1:0] gnt,
    output logic               c_a,
    output logic               c_b,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    // First set request at or after ptr, wrapping; descending scan so the smallest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        int unsigned      k;
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (r[k]) begin
                pick = k[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               ca_q, ca_d;
    logic               cb_q, cb_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               q_s;
    logic               to_hit;

    muller_c_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (c_q),
        .q       (q_s)
    );

    // A zero limit disables the timeout; the compare is widened so a full-scale limit still hits.
    assign to_hit = (timeout_lim != '0) &&
                    (({1'b0, cnt_q} + (TO_W + 1)'(1)) >= {1'b0, timeout_lim});

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        code_d  = code_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, rr_q);
                    gnt_d   = NUM_REQ'(1) << idx_d;
                    state_d = SET_A;
                end
            end
            SET_A: begin
                if (q_s) begin
                    state_d = ERR;
                    code_d  = ERR_HOLD;
                end else if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    state_d = SET_B;
                end
            end
            SET_B: begin
                if (q_s) begin
                    state_d = CLR;
                end else if (to_hit) begin
                    state_d = ERR;
                    code_d  = ERR_RISE_TO;
                end
            end
            CLR: begin
                if (!q_s) begin
                    state_d = FIN;
                end else if (to_hit) begin
                    state_d = ERR;
                    code_d  = ERR_FALL_TO;
                end
            end
            FIN: begin
                gnt_d   = '0;
                rr_d    = next_ptr(idx_q);
                state_d = IDLE;
            end
            ERR: begin
                if (!q_s) begin
                    gnt_d   = '0;
                    rr_d    = next_ptr(idx_q);
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Both counters restart on every state entry and saturate rather than wrap.
        if (state_d != state_q) begin
            cnt_d  = '0;
            hold_d = '0;
        end else begin
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);
            hold_d = (&hold_q) ? hold_q : hold_q + HOLD_W'(1);
        end

        ca_d   = (state_d == SET_A) || (state_d == SET_B);
        cb_d   = (state_d == SET_B);
        done_d = (state_d == FIN);
        err_d  = (state_d == ERR) && (state_q != ERR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            ca_q    <= 1'b0;
            cb_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign gnt      = gnt_q;
    assign c_a      = ca_q;
    assign c_b      = cb_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule
